// File: rtl/mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller
//   Control unit of the multicycle MIPS CPU. A Moore FSM steps each
//   instruction through fetch, decode, execute, memory and writeback. An ALU
//   decoder turns the FSM's aluop (and funct, for R-type) into the ALU
//   function code.
//
// Ports
//   clk         in   1  single clock, rising edge
//   reset       in   1  synchronous, active-high; loads FETCH
//   op          in   6  instruction[31:26]
//   funct       in   6  instruction[5:0]
//   zero        in   1  ALU result == 0
//   pcen        out  1  PC write enable (pcwrite | branch&zero | branchne&~zero)
//   memwrite    out  1  memory write enable
//   irwrite     out  1  instruction register write enable
//   regwrite    out  1  register file write enable
//   alusrca     out  1  0: PC, 1: register A
//   iord        out  1  0: address = PC, 1: address = ALUOut
//   memtoreg    out  1  0: ALUOut, 1: data register
//   regdst      out  1  0: rt, 1: rd
//   alusrcb     out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc       out  2  00 ALUResult, 01 ALUOut, 10 jump target
//   alucontrol  out  4  ALU function code
//   state_dbg   out  4  current FSM state encoding (observability only)
//
// Handshake: none. The controller has no valid/ready interface; op, funct
// and zero are sampled every cycle and op must be held stable for the whole
// instruction (it is re-examined in DECODE, MEMADR and IMMEX).
// ---------------------------------------------------------------------------
module mips_multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] alucontrol,
   output logic [3:0] state_dbg
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   // aluop encodings
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;
   localparam logic [2:0] ALUOP_SLT   = 3'b101;

   // ALU function codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      BNEEX   = 4'd9,
      IMMEX   = 4'd10,
      IMMWB   = 4'd11,
      JEX     = 4'd12
   } state_t;

   state_t     state, state_n;
   logic [2:0] aluop;

   // Raw Moore outputs before reset gating
   logic pcwrite, branch, branchne;
   logic memwrite_s, irwrite_s, regwrite_s;

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_n;
   end

   assign state_dbg = state;

   // -------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------
   always_comb begin
      state_n = FETCH;
      case (state)
         FETCH:  state_n = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:                       state_n = MEMADR;
               OP_RTYPE:                           state_n = RTYPEEX;
               OP_BEQ:                             state_n = BEQEX;
               OP_BNE:                             state_n = BNEEX;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_n = IMMEX;
               OP_J:                               state_n = JEX;
               default:                            state_n = FETCH; // unknown op: drop it
            endcase
         end
         MEMADR: begin
            if (op == OP_LW)      state_n = MEMRD;
            else if (op == OP_SW) state_n = MEMWR;
            else                  state_n = FETCH; // op changed underneath us
         end
         MEMRD:   state_n = MEMWB;
         MEMWB:   state_n = FETCH;
         MEMWR:   state_n = FETCH;
         RTYPEEX: state_n = RTYPEWB;
         RTYPEWB: state_n = FETCH;
         BEQEX:   state_n = FETCH;
         BNEEX:   state_n = FETCH;
         IMMEX:   state_n = IMMWB;
         IMMWB:   state_n = FETCH;
         JEX:     state_n = FETCH;
         default: state_n = FETCH;
      endcase
   end

   // -------------------------------------------------------------------
   // Moore output decode
   // -------------------------------------------------------------------
   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchne   = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = ALUOP_ADD;
      case (state)
         FETCH: begin
            alusrcb   = 2'b01;
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
         end
         DECODE: begin
            // Precompute the branch target while the opcode is decoded
            alusrcb = 2'b11;
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: begin
            iord = 1'b1;
         end
         MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         BNEEX: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_SUB;
            pcsrc    = 2'b01;
            branchne = 1'b1;
         end
         IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
               OP_ANDI: aluop = ALUOP_AND;
               OP_ORI:  aluop = ALUOP_OR;
               OP_SLTI: aluop = ALUOP_SLT;
               default: aluop = ALUOP_ADD; // ADDI
            endcase
         end
         IMMWB: begin
            regwrite_s = 1'b1;
         end
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are held off while reset is asserted so an aborted
   // instruction can never commit anything.
   assign pcen     = ~reset & (pcwrite | (branch & zero) | (branchne & ~zero));
   assign irwrite  = ~reset & irwrite_s;
   assign memwrite = ~reset & memwrite_s;
   assign regwrite = ~reset & regwrite_s;

   // -------------------------------------------------------------------
   // ALU decoder
   // -------------------------------------------------------------------
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_AND: alucontrol = ALU_AND;
         ALUOP_OR:  alucontrol = ALU_OR;
         ALUOP_SLT: alucontrol = ALU_SLT;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               FN_NOR:  alucontrol = ALU_NOR;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_controller
//   Directed instruction sequences for the multicycle controller. Each driven
//   cycle pushes a hand-written expected output vector; a monitor on the
//   falling edge pops and compares it against the DUT.
//
// Vector layout (23 bits, MSB first):
//   state[3:0] aluop[2:0] alucontrol[3:0] pcsrc[1:0] alusrcb[1:0]
//   pcen memwrite irwrite regwrite alusrca iord memtoreg regdst
// ---------------------------------------------------------------------------
module tb_mips_multicycle_controller;

   localparam int W = 23;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b000000;
   logic [5:0] funct = 6'b100010;
   logic       zero = 1'b0;

   logic       pcen, memwrite, irwrite, regwrite;
   logic       alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol, state_dbg;

   always #5 clk = ~clk;

   mips_multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .state_dbg  (state_dbg)
   );

   // ---------------- expected vectors ----------------
   function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [2:0] aop,
                                       input logic [3:0] ctl, input logic [1:0] psrc,
                                       input logic [1:0] srcb, input logic [7:0] flags);
      return {st, aop, ctl, psrc, srcb, flags};
   endfunction

   // flags: pcen memwrite irwrite regwrite alusrca iord memtoreg regdst
   localparam logic [W-1:0] E_FETCH_RST = mk(4'd0,  3'b000, 4'b0010, 2'b00, 2'b01, 8'b0000_0000);
   localparam logic [W-1:0] E_FETCH     = mk(4'd0,  3'b000, 4'b0010, 2'b00, 2'b01, 8'b1010_0000);
   localparam logic [W-1:0] E_DECODE    = mk(4'd1,  3'b000, 4'b0010, 2'b00, 2'b11, 8'b0000_0000);
   localparam logic [W-1:0] E_MEMADR    = mk(4'd2,  3'b000, 4'b0010, 2'b00, 2'b10, 8'b0000_1000);
   localparam logic [W-1:0] E_MEMRD     = mk(4'd3,  3'b000, 4'b0010, 2'b00, 2'b00, 8'b0000_0100);
   localparam logic [W-1:0] E_MEMWB     = mk(4'd4,  3'b000, 4'b0010, 2'b00, 2'b00, 8'b0001_0010);
   localparam logic [W-1:0] E_MEMWR     = mk(4'd5,  3'b000, 4'b0010, 2'b00, 2'b00, 8'b0100_0100);
   localparam logic [W-1:0] E_REX_SUB   = mk(4'd6,  3'b010, 4'b0110, 2'b00, 2'b00, 8'b0000_1000);
   localparam logic [W-1:0] E_REX_NOR   = mk(4'd6,  3'b010, 4'b1100, 2'b00, 2'b00, 8'b0000_1000);
   localparam logic [W-1:0] E_REX_DEF   = mk(4'd6,  3'b010, 4'b0010, 2'b00, 2'b00, 8'b0000_1000);
   localparam logic [W-1:0] E_RWB       = mk(4'd7,  3'b000, 4'b0010, 2'b00, 2'b00, 8'b0001_0001);
   localparam logic [W-1:0] E_RWB_RST   = mk(4'd7,  3'b000, 4'b0010, 2'b00, 2'b00, 8'b0000_0001);
   localparam logic [W-1:0] E_BEQ_T     = mk(4'd8,  3'b001, 4'b0110, 2'b01, 2'b00, 8'b1000_1000);
   localparam logic [W-1:0] E_BEQ_NT    = mk(4'd8,  3'b001, 4'b0110, 2'b01, 2'b00, 8'b0000_1000);
   localparam logic [W-1:0] E_BNE_T     = mk(4'd9,  3'b001, 4'b0110, 2'b01, 2'b00, 8'b1000_1000);
   localparam logic [W-1:0] E_BNE_NT    = mk(4'd9,  3'b001, 4'b0110, 2'b01, 2'b00, 8'b0000_1000);
   localparam logic [W-1:0] E_IMM_ADD   = mk(4'd10, 3'b000, 4'b0010, 2'b00, 2'b10, 8'b0000_1000);
   localparam logic [W-1:0] E_IMM_AND   = mk(4'd10, 3'b011, 4'b0000, 2'b00, 2'b10, 8'b0000_1000);
   localparam logic [W-1:0] E_IMM_OR    = mk(4'd10, 3'b100, 4'b0001, 2'b00, 2'b10, 8'b0000_1000);
   localparam logic [W-1:0] E_IMM_SLT   = mk(4'd10, 3'b101, 4'b0111, 2'b00, 2'b10, 8'b0000_1000);
   localparam logic [W-1:0] E_IMMWB     = mk(4'd11, 3'b000, 4'b0010, 2'b00, 2'b00, 8'b0001_0000);
   localparam logic [W-1:0] E_JEX       = mk(4'd12, 3'b000, 4'b0010, 2'b10, 2'b00, 8'b1000_0000);

   localparam logic [5:0] R    = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ANDI = 6'b001100;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] SLTI = 6'b001010;
   localparam logic [5:0] J    = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   // ---------------- driver ----------------
   task automatic step(input string nm, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic [W-1:0] e);
      @(posedge clk);
      #1;
      reset = rst;
      op    = o;
      funct = f;
      zero  = z;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e, a;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {state_dbg, dut.aluop, alucontrol, pcsrc, alusrcb,
               pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", nm, a, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset, then R-type SUB
      step("reset_state", 1'b1, R, 6'b100010, 1'b0, E_FETCH_RST);
      step("r_fetch",   1'b0, R, 6'b100010, 1'b0, E_FETCH);
      step("r_decode",  1'b0, R, 6'b100010, 1'b0, E_DECODE);
      step("r_ex_sub",  1'b0, R, 6'b100010, 1'b0, E_REX_SUB);
      step("r_wb",      1'b0, R, 6'b100010, 1'b0, E_RWB);
      // LW: 5 cycles
      step("lw_fetch",  1'b0, LW, 6'b0, 1'b0, E_FETCH);
      step("lw_decode", 1'b0, LW, 6'b0, 1'b0, E_DECODE);
      step("lw_memadr", 1'b0, LW, 6'b0, 1'b0, E_MEMADR);
      step("lw_memrd",  1'b0, LW, 6'b0, 1'b0, E_MEMRD);
      step("lw_memwb",  1'b0, LW, 6'b0, 1'b0, E_MEMWB);
      // SW: 4 cycles
      step("sw_fetch",  1'b0, SW, 6'b0, 1'b0, E_FETCH);
      step("sw_decode", 1'b0, SW, 6'b0, 1'b0, E_DECODE);
      step("sw_memadr", 1'b0, SW, 6'b0, 1'b0, E_MEMADR);
      step("sw_memwr",  1'b0, SW, 6'b0, 1'b0, E_MEMWR);
      // BEQ taken / not taken
      step("beq1_fetch",  1'b0, BEQ, 6'b0, 1'b0, E_FETCH);
      step("beq1_decode", 1'b0, BEQ, 6'b0, 1'b0, E_DECODE);
      step("beq_taken",   1'b0, BEQ, 6'b0, 1'b1, E_BEQ_T);
      step("beq0_fetch",  1'b0, BEQ, 6'b0, 1'b0, E_FETCH);
      step("beq0_decode", 1'b0, BEQ, 6'b0, 1'b0, E_DECODE);
      step("beq_nottaken",1'b0, BEQ, 6'b0, 1'b0, E_BEQ_NT);
      // BNE: inverse sense of zero
      step("bne1_fetch",  1'b0, BNE, 6'b0, 1'b0, E_FETCH);
      step("bne1_decode", 1'b0, BNE, 6'b0, 1'b0, E_DECODE);
      step("bne_nottaken",1'b0, BNE, 6'b0, 1'b1, E_BNE_NT);
      step("bne0_fetch",  1'b0, BNE, 6'b0, 1'b0, E_FETCH);
      step("bne0_decode", 1'b0, BNE, 6'b0, 1'b0, E_DECODE);
      step("bne_taken",   1'b0, BNE, 6'b0, 1'b0, E_BNE_T);
      // J
      step("j_fetch",   1'b0, J, 6'b0, 1'b0, E_FETCH);
      step("j_decode",  1'b0, J, 6'b0, 1'b0, E_DECODE);
      step("j_ex",      1'b0, J, 6'b0, 1'b0, E_JEX);
      // Immediate ops
      step("ori_fetch",  1'b0, ORI, 6'b0, 1'b0, E_FETCH);
      step("ori_decode", 1'b0, ORI, 6'b0, 1'b0, E_DECODE);
      step("ori_ex",     1'b0, ORI, 6'b0, 1'b0, E_IMM_OR);
      step("ori_wb",     1'b0, ORI, 6'b0, 1'b0, E_IMMWB);
      step("andi_fetch", 1'b0, ANDI, 6'b0, 1'b0, E_FETCH);
      step("andi_decode",1'b0, ANDI, 6'b0, 1'b0, E_DECODE);
      step("andi_ex",    1'b0, ANDI, 6'b0, 1'b0, E_IMM_AND);
      step("andi_wb",    1'b0, ANDI, 6'b0, 1'b0, E_IMMWB);
      step("slti_fetch", 1'b0, SLTI, 6'b0, 1'b0, E_FETCH);
      step("slti_decode",1'b0, SLTI, 6'b0, 1'b0, E_DECODE);
      step("slti_ex",    1'b0, SLTI, 6'b0, 1'b0, E_IMM_SLT);
      step("slti_wb",    1'b0, SLTI, 6'b0, 1'b0, E_IMMWB);
      step("addi_fetch", 1'b0, ADDI, 6'b0, 1'b0, E_FETCH);
      step("addi_decode",1'b0, ADDI, 6'b0, 1'b0, E_DECODE);
      step("addi_ex",    1'b0, ADDI, 6'b0, 1'b0, E_IMM_ADD);
      step("addi_wb",    1'b0, ADDI, 6'b0, 1'b0, E_IMMWB);
      // R-type NOR and an unlisted funct
      step("nor_fetch",  1'b0, R, 6'b100111, 1'b0, E_FETCH);
      step("nor_decode", 1'b0, R, 6'b100111, 1'b0, E_DECODE);
      step("nor_ex",     1'b0, R, 6'b100111, 1'b0, E_REX_NOR);
      step("nor_wb",     1'b0, R, 6'b100111, 1'b0, E_RWB);
      step("rdef_fetch", 1'b0, R, 6'b000000, 1'b0, E_FETCH);
      step("rdef_decode",1'b0, R, 6'b000000, 1'b0, E_DECODE);
      step("rdef_ex",    1'b0, R, 6'b000000, 1'b0, E_REX_DEF);
      step("rdef_wb",    1'b0, R, 6'b000000, 1'b0, E_RWB);
      // Reset during MEMRD aborts the load
      step("lwr_fetch",  1'b0, LW, 6'b0, 1'b0, E_FETCH);
      step("lwr_decode", 1'b0, LW, 6'b0, 1'b0, E_DECODE);
      step("lwr_memadr", 1'b0, LW, 6'b0, 1'b0, E_MEMADR);
      step("lwr_memrd_rst", 1'b1, LW, 6'b0, 1'b0, E_MEMRD);
      // Unknown opcode goes DECODE -> FETCH with no writes
      step("lwr_abort_fetch", 1'b0, BAD, 6'b0, 1'b0, E_FETCH);
      step("bad_decode", 1'b0, BAD, 6'b0, 1'b0, E_DECODE);
      step("bad_refetch",1'b0, R, 6'b100010, 1'b0, E_FETCH);
      // Reset during RTYPEWB must suppress regwrite
      step("rr_decode",  1'b0, R, 6'b100010, 1'b0, E_DECODE);
      step("rr_ex",      1'b0, R, 6'b100010, 1'b0, E_REX_SUB);
      step("rr_wb_rst",  1'b1, R, 6'b100010, 1'b0, E_RWB_RST);
      step("rr_fetch_rst", 1'b1, R, 6'b100010, 1'b0, E_FETCH_RST);
      step("rr_fetch",   1'b0, R, 6'b100010, 1'b0, E_FETCH);
      step("rr_decode2", 1'b0, R, 6'b100010, 1'b0, E_DECODE);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
